// File: rtl/cpu_pkg.sv
// Shared types and instruction-field positions for the 8-bit CPU control unit.
// Branch support is selected by the CPU_CTRL_BRANCH_EN macro in instr_decode and cpu_ctrl.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LDI  = 4'd6,
    OP_MOV  = 4'd7,
    OP_JMP  = 4'd8,
    OP_BZ   = 4'd9,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } ctrl_state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the latched instruction word into register-file and ALU controls.
// CPU_CTRL_BRANCH_EN enables JMP/BZ; without it opcodes 8 and 9 decode as NOP.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  output logic [3:0]  wa,
  output logic [2:0]  alu_op,
  output logic [7:0]  imm,
  output logic        imm_sel,
  output logic        is_write,
  output logic        is_branch,
  output logic        is_cond,
  output logic        is_halt
);

  opcode_e    opcode;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;

  assign opcode = opcode_e'(instr[OPC_MSB:OPC_LSB]);
  assign rd     = instr[RD_MSB:RD_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    ra1       = rs1;
    ra2       = rs2;
    wa        = rd;
    alu_op    = ALU_ADD;
    imm       = instr[IMM_MSB:IMM_LSB];
    imm_sel   = 1'b0;
    is_write  = 1'b0;
    is_branch = 1'b0;
    is_cond   = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ADD: begin alu_op = ALU_ADD; is_write = 1'b1; end
      OP_SUB: begin alu_op = ALU_SUB; is_write = 1'b1; end
      OP_AND: begin alu_op = ALU_AND; is_write = 1'b1; end
      OP_OR:  begin alu_op = ALU_OR;  is_write = 1'b1; end
      OP_XOR: begin alu_op = ALU_XOR; is_write = 1'b1; end
      OP_LDI: begin
        alu_op   = ALU_PASS_B;
        imm_sel  = 1'b1;
        is_write = 1'b1;
      end
      // MOV routes rs1 through the B port so the ALU can pass it unchanged.
      OP_MOV: begin
        alu_op   = ALU_PASS_B;
        ra2      = rs1;
        is_write = 1'b1;
      end
`ifdef CPU_CTRL_BRANCH_EN
      OP_JMP: is_branch = 1'b1;
      OP_BZ: begin
        is_branch = 1'b1;
        is_cond   = 1'b1;
        ra1       = rd;
      end
`endif
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer and program counter for the 8-bit CPU.
// Define CPU_CTRL_BRANCH_EN to enable JMP/BZ; otherwise they behave as NOP.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      RA1,
  output logic [3:0]      RA2,
  output logic [3:0]      WA,
  output logic            write_enable,
  input  logic [7:0]      RD1,
  output logic [2:0]      alu_op,
  output logic [7:0]      imm,
  output logic            imm_sel,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  ctrl_state_e     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic            imem_req_q, imem_req_d;
  logic            write_enable_q, write_enable_d;
  logic            halted_q, halted_d;

  logic is_write, is_branch, is_cond, is_halt, branch_taken;
  logic [PC_W-1:0] branch_target;

  instr_decode u_decode (
    .instr     (instr_q),
    .ra1       (RA1),
    .ra2       (RA2),
    .wa        (WA),
    .alu_op    (alu_op),
    .imm       (imm),
    .imm_sel   (imm_sel),
    .is_write  (is_write),
    .is_branch (is_branch),
    .is_cond   (is_cond),
    .is_halt   (is_halt)
  );

  assign branch_target = PC_W'(imm);

`ifdef CPU_CTRL_BRANCH_EN
  assign branch_taken = is_branch && (!is_cond || RD1 == 8'h00);
`else
  logic unused_branch;
  assign unused_branch = ^{RD1, is_branch, is_cond};
  assign branch_taken  = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    imem_req_d     = imem_req_q;
    write_enable_d = 1'b0;
    halted_d       = halted_q;
    case (state_q)
      // The request is registered, so an ack only counts once the request is visible.
      ST_FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          instr_d    = imem_data;
          imem_req_d = 1'b0;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (is_write) begin
          state_d        = ST_WRITEBACK;
          write_enable_d = (WA != 4'd0);
        end else begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
          pc_d       = branch_taken ? branch_target : pc_q + PC_W'(1);
        end
      end
      ST_WRITEBACK: begin
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
        pc_d       = pc_q + PC_W'(1);
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      instr_q        <= 16'h0000;
      imem_req_q     <= 1'b0;
      write_enable_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      imem_req_q     <= imem_req_d;
      write_enable_q <= write_enable_d;
      halted_q       <= halted_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign write_enable = write_enable_q;
  assign halted       = halted_q;

endmodule
